apb_route_ctrl: RTL and testbench
=================================

APB_ROUTE_CTRL -- requirements
Module: apb_route_ctrl

Interface
REQ-001 SHALL have parameter NUM_COMP, default 4: number of completers (2..15).
REQ-002 SHALL have parameter CID_W, default 4: comp_id width; 2**CID_W > NUM_COMP.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16: REQ-state cycles before timeout; 0 disables timeout; maximum 65535.
REQ-004 SHALL derive localparam SEL_W = $clog2(NUM_COMP+1); code 0 = no route, code k+1 = completer k.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port psel  input  1  requester select; a transaction lasts while it is high.
REQ-008 SHALL have port comp_id  input  CID_W  target completer index, sampled only at transaction start.
REQ-009 SHALL have port cn_ready  input  NUM_COMP  per-completer ready.
REQ-010 SHALL have port rn_valid  output  NUM_COMP  one-hot request to the target completer.
REQ-011 SHALL have port crossbar_sel  output  SEL_W  crossbar mux select.
REQ-012 SHALL have port route_err  output  1  unmapped comp_id.
REQ-013 SHALL have port timeout_err  output  1  completer not ready in time.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when XFER ends normally.

Function
REQ-016 SHALL use FSM states IDLE, REQ, XFER, ERR; all outputs registered and driven from the state plus the latched id (tgt).
REQ-017 IDLE with psel=1 at an edge SHALL latch tgt=comp_id; if comp_id<NUM_COMP go to REQ, else go to ERR with route_err=1.
REQ-018 In REQ: rn_valid = one-hot(tgt); crossbar_sel = 0; wait counter cleared on REQ entry.
REQ-019 REQ with cn_ready[tgt]=1 at an edge SHALL go to XFER with crossbar_sel = tgt+1 visible the next cycle; cn_ready of other bits ignored.
REQ-020 REQ with cn_ready[tgt]=0 SHALL increment the counter; if the counter equals TIMEOUT_CYC-1 at that edge (TIMEOUT_CYC>0), go to ERR with timeout_err=1.
REQ-021 In XFER: rn_valid and crossbar_sel held; cn_ready[tgt] low at an edge SHALL return to REQ, clear crossbar_sel, and restart the counter.
REQ-022 psel=0 at an edge in REQ or XFER SHALL go to IDLE, clearing rn_valid and crossbar_sel; from XFER, done=1 for exactly that next cycle.
REQ-023 In ERR: rn_valid=0 and crossbar_sel=0; the error flag is held until psel=0 at an edge, then IDLE with both error flags cleared.
REQ-024 Priority within one edge SHALL be: rst_n low > psel low > cn_ready[tgt] high > timeout.
REQ-025 comp_id changes after transaction start SHALL be ignored until the next IDLE exit.
REQ-026 psel held high across a return to IDLE SHALL start a new transaction on the following edge (one IDLE cycle minimum between transactions).
REQ-027 The counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide (minimum 1) and SHALL saturate, never wrap.
REQ-028 route_err and timeout_err SHALL never be high together; rn_valid SHALL be zero or one-hot at all times.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, tgt=0, counter=0, and all outputs 0 on the next cycle, regardless of state or psel.
REQ-030 Reset mid-XFER SHALL not produce a done pulse.

Verification
REQ-031 Bench (NUM_COMP=4, TIMEOUT_CYC=8) SHALL cover: psel=1, comp_id=2, cn_ready=4'b0100 two cycles later -> rn_valid=4'b0100 on cycle 1, crossbar_sel=3 on cycle 3; psel drop -> outputs 0 and done=1 for one cycle.
REQ-032 comp_id=5 with psel=1 -> route_err=1, rn_valid=0 until psel=0, then route_err=0.
REQ-033 comp_id=1 with cn_ready=0 held -> rn_valid=4'b0010 for 8 cycles, then timeout_err=1 and rn_valid=0.
REQ-034 XFER on completer 0, then cn_ready[0] dropped one cycle -> crossbar_sel 1->0->1, busy stays 1, no done pulse.
REQ-035 rst_n=0 during XFER -> next cycle all outputs 0, busy=0, done=0.
REQ-036 Same edge: psel=0 and cn_ready[tgt]=1 in REQ -> IDLE, crossbar_sel stays 0.

Source files
------------

// File: rtl/apb_route_ctrl.sv
// apb_route_ctrl
//   Routes one APB-style requester to one of NUM_COMP completers. A transaction
//   starts when psel is seen high in IDLE. At that point comp_id is latched as the
//   target. The controller requests the target (rn_valid) and waits for its
//   ready. While the target is ready it holds the crossbar select. It flags an
//   unmapped id (route_err) or a completer that stays silent too long
//   (timeout_err). Every output comes straight from a flop.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   psel          requester select; a transaction lasts while it is high
//   comp_id       target completer index, sampled only at transaction start
//   cn_ready      per-completer ready
//   rn_valid      one-hot request to the target completer
//   crossbar_sel  0 = no route, k+1 = completer k
//   route_err     comp_id did not map to a completer
//   timeout_err   target completer was not ready within TIMEOUT_CYC cycles
//   busy          controller is not IDLE
//   done          one-cycle pulse when a transfer ends normally
module apb_route_ctrl #(
  parameter int unsigned NUM_COMP    = 4,
  parameter int unsigned CID_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned SEL_W      = $clog2(NUM_COMP + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic [CID_W-1:0]    comp_id,
  input  logic [NUM_COMP-1:0] cn_ready,
  output logic [NUM_COMP-1:0] rn_valid,
  output logic [SEL_W-1:0]    crossbar_sel,
  output logic                route_err,
  output logic                timeout_err,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CID_W-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_COMP-1:0] rn_valid_q, rn_valid_d;
  logic [SEL_W-1:0]    crossbar_sel_q, crossbar_sel_d;
  logic                route_err_q, route_err_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NUM_COMP-1:0] tgt_oh_q, tgt_oh_d;
  logic                ready_tgt;

  // One-hot decodes of the current and next target. Matching against the
  // one-hot avoids indexing cn_ready with the wider CID_W-bit id.
  always_comb begin
    tgt_oh_q = '0;
    tgt_oh_d = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      tgt_oh_q[i] = (tgt_q == CID_W'(i));
      tgt_oh_d[i] = (tgt_d == CID_W'(i));
    end
  end

  assign ready_tgt = |(cn_ready & tgt_oh_q);

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    cnt_d         = cnt_q;
    route_err_d   = route_err_q;
    timeout_err_d = timeout_err_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel) begin
          tgt_d = comp_id;
          cnt_d = '0;
          if (comp_id < CID_W'(NUM_COMP)) begin
            state_d = ST_REQ;
          end else begin
            state_d     = ST_ERR;
            route_err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (ready_tgt) begin
          state_d = ST_XFER;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_XFER: begin
        if (!psel) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (!ready_tgt) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_ERR: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Error flags only live in ERR; leaving it clears both.
    if (state_d != ST_ERR) begin
      route_err_d   = 1'b0;
      timeout_err_d = 1'b0;
    end

    // Outputs are computed from the next state so that they are registered
    // and still take effect in the cycle that follows the deciding edge.
    rn_valid_d     = ((state_d == ST_REQ) || (state_d == ST_XFER)) ? tgt_oh_d : '0;
    crossbar_sel_d = (state_d == ST_XFER) ? (SEL_W'(tgt_d) + SEL_W'(1)) : '0;
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tgt_q          <= '0;
      cnt_q          <= '0;
      rn_valid_q     <= '0;
      crossbar_sel_q <= '0;
      route_err_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tgt_q          <= tgt_d;
      cnt_q          <= cnt_d;
      rn_valid_q     <= rn_valid_d;
      crossbar_sel_q <= crossbar_sel_d;
      route_err_q    <= route_err_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign rn_valid     = rn_valid_q;
  assign crossbar_sel = crossbar_sel_q;
  assign route_err    = route_err_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_apb_route_ctrl.sv
// Directed bench for apb_route_ctrl (NUM_COMP=4, TIMEOUT_CYC=8). A row applies
// inputs, waits one rising edge, and compares the outputs that follow.
module tb_apb_route_ctrl;

  localparam int unsigned NUM_COMP    = 4;
  localparam int unsigned CID_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel;
  logic [3:0] comp_id;
  logic [3:0] cn_ready;
  logic [3:0] rn_valid;
  logic [2:0] crossbar_sel;
  logic       route_err;
  logic       timeout_err;
  logic       busy;
  logic       done;

  int n_cmp   = 0;
  int n_bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  apb_route_ctrl #(
    .NUM_COMP   (NUM_COMP),
    .CID_W      (CID_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psel        (psel),
    .comp_id     (comp_id),
    .cn_ready    (cn_ready),
    .rn_valid    (rn_valid),
    .crossbar_sel(crossbar_sel),
    .route_err   (route_err),
    .timeout_err (timeout_err),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic       rst_n;
    logic       psel;
    logic [3:0] id;
    logic [3:0] rdy;
    logic [3:0] rn;
    logic [2:0] sel;
    logic       rerr;
    logic       terr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic p, input logic [3:0] id,
                              input logic [3:0] rdy, input logic [3:0] rn,
                              input logic [2:0] sel, input logic rerr,
                              input logic terr, input logic b, input logic d);
    vec_t v;
    v.rst_n = r;  v.psel = p;  v.id = id;     v.rdy = rdy;
    v.rn = rn;    v.sel = sel; v.rerr = rerr; v.terr = terr;
    v.busy = b;   v.done = d;
    return v;
  endfunction

  task automatic apply(input logic r, input logic p, input logic [3:0] id,
                       input logic [3:0] rdy);
    rst_n    = r;
    psel     = p;
    comp_id  = id;
    cn_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] rn,
                            input logic [2:0] sel, input logic rerr,
                            input logic terr, input logic b, input logic d);
    n_cmp++;
    if ({rn_valid, crossbar_sel, route_err, timeout_err, busy, done} !==
        {rn, sel, rerr, terr, b, d}) begin
      n_bad++;
      $display("FAIL %s: got rn=%b sel=%0d rerr=%b terr=%b busy=%b done=%b, want rn=%b sel=%0d rerr=%b terr=%b busy=%b done=%b",
               tag, rn_valid, crossbar_sel, route_err, timeout_err, busy, done,
               rn, sel, rerr, terr, b, d);
    end
  endtask

  // Structural invariants checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (!$onehot0(rn_valid) || (route_err && timeout_err)) begin
        n_bad++;
        $display("FAIL invariant: got rn=%b rerr=%b terr=%b, want rn zero/one-hot and not both errors",
                 rn_valid, route_err, timeout_err);
      end
    end
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; comp_id = '0; cn_ready = '0;

    //                rst psel id     rdy      rn       sel  re te bz dn
    vecs.push_back(mk(0, 0, 4'd0, 4'b0000, 4'b0000, 3'd0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 4'd2, 4'b1111, 4'b0000, 3'd0, 0, 0, 0, 0)); // reset beats psel
    vecs.push_back(mk(1, 1, 4'd2, 4'b0000, 4'b0100, 3'd0, 0, 0, 1, 0)); // cycle 1: REQ
    vecs.push_back(mk(1, 1, 4'd2, 4'b0000, 4'b0100, 3'd0, 0, 0, 1, 0)); // cycle 2
    vecs.push_back(mk(1, 1, 4'd7, 4'b0100, 4'b0100, 3'd3, 0, 0, 1, 0)); // cycle 3: XFER, id ignored
    vecs.push_back(mk(1, 1, 4'd0, 4'b0100, 4'b0100, 3'd3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 4'd0, 4'b0100, 4'b0000, 3'd0, 0, 0, 0, 1)); // done pulse
    vecs.push_back(mk(1, 0, 4'd0, 4'b0100, 4'b0000, 3'd0, 0, 0, 0, 0)); // pulse ends
    vecs.push_back(mk(1, 1, 4'd5, 4'b1111, 4'b0000, 3'd0, 1, 0, 1, 0)); // unmapped id
    vecs.push_back(mk(1, 1, 4'd1, 4'b1111, 4'b0000, 3'd0, 1, 0, 1, 0)); // held in ERR
    vecs.push_back(mk(1, 0, 4'd1, 4'b1111, 4'b0000, 3'd0, 0, 0, 0, 0)); // cleared
    vecs.push_back(mk(1, 1, 4'd15, 4'b0000, 4'b0000, 3'd0, 1, 0, 1, 0)); // max id unmapped
    vecs.push_back(mk(1, 0, 4'd0, 4'b0000, 4'b0000, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'd3, 4'b0000, 4'b1000, 3'd0, 0, 0, 1, 0)); // REQ on 3
    vecs.push_back(mk(1, 0, 4'd3, 4'b1000, 4'b0000, 3'd0, 0, 0, 0, 0)); // psel low beats ready
    vecs.push_back(mk(1, 1, 4'd0, 4'b0000, 4'b0001, 3'd0, 0, 0, 1, 0)); // REQ on 0
    vecs.push_back(mk(1, 1, 4'd0, 4'b0001, 4'b0001, 3'd1, 0, 0, 1, 0)); // XFER
    vecs.push_back(mk(1, 1, 4'd0, 4'b1110, 4'b0001, 3'd0, 0, 0, 1, 0)); // ready[0] drop
    vecs.push_back(mk(1, 1, 4'd0, 4'b0001, 4'b0001, 3'd1, 0, 0, 1, 0)); // back to XFER
    vecs.push_back(mk(1, 1, 4'd0, 4'b0001, 4'b0001, 3'd1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0, 4'b0001, 4'b0000, 3'd0, 0, 0, 0, 0)); // reset mid-XFER
    vecs.push_back(mk(1, 1, 4'd1, 4'b0000, 4'b0010, 3'd0, 0, 0, 1, 0)); // no done, new start
    vecs.push_back(mk(1, 0, 4'd1, 4'b0000, 4'b0000, 3'd0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].psel, vecs[i].id, vecs[i].rdy);
      expect_out($sformatf("row%0d", i), vecs[i].rn, vecs[i].sel,
                 vecs[i].rerr, vecs[i].terr, vecs[i].busy, vecs[i].done);
      started = 1'b1;
    end

    // Timeout: eight REQ cycles on completer 1, other readies ignored.
    apply(1, 1, 4'd1, 4'b0000);
    expect_out("to_req1", 4'b0010, 3'd0, 0, 0, 1, 0);
    for (int k = 2; k <= 8; k++) begin
      apply(1, 1, 4'(k), 4'b1101);
      expect_out($sformatf("to_req%0d", k), 4'b0010, 3'd0, 0, 0, 1, 0);
    end
    apply(1, 1, 4'd1, 4'b1101);
    expect_out("to_err", 4'b0000, 3'd0, 0, 1, 1, 0);
    apply(1, 1, 4'd1, 4'b1111);
    expect_out("to_hold", 4'b0000, 3'd0, 0, 1, 1, 0);
    apply(1, 0, 4'd1, 4'b0000);
    expect_out("to_clear", 4'b0000, 3'd0, 0, 0, 0, 0);

    // Ready on the last edge before timeout wins.
    apply(1, 1, 4'd1, 4'b0000);
    expect_out("late_req1", 4'b0010, 3'd0, 0, 0, 1, 0);
    for (int k = 2; k <= 8; k++) begin
      apply(1, 1, 4'd1, 4'b0000);
      expect_out($sformatf("late_req%0d", k), 4'b0010, 3'd0, 0, 0, 1, 0);
    end
    apply(1, 1, 4'd1, 4'b0010);
    expect_out("late_xfer", 4'b0010, 3'd2, 0, 0, 1, 0);
    apply(1, 0, 4'd1, 4'b0010);
    expect_out("late_done", 4'b0000, 3'd0, 0, 0, 0, 1);
    apply(1, 0, 4'd1, 4'b0000);
    expect_out("late_idle", 4'b0000, 3'd0, 0, 0, 0, 0);

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
